// File: rtl/tone_pkg.sv
// Shared types for the tone engine voice datapath: waveform select, amplitude limits, scheduler states.
// Pure declarations; no latency, no flow control.
package tone_pkg;

    typedef enum logic [1:0] {
        WAVE_SQUARE = 2'd0,
        WAVE_SAW    = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_OFF    = 2'd3
    } wave_sel_e;

    localparam logic signed [11:0] WAVE_POS_MAX = 12'sd2047;
    localparam logic signed [11:0] WAVE_NEG_MAX = -12'sd2048;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_ACC   = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/voice_wave_gen.sv
// Combinational waveform lookup and volume scaling for one voice: (phase top bits, wave, vol) -> signed product.
// Zero latency; no flow control.
module voice_wave_gen
    import tone_pkg::*;
#(
    parameter int VOL_W = 4
) (
    input  logic [12:0]              phase_top_i,
    input  wave_sel_e                wave_sel_i,
    input  logic [VOL_W-1:0]         vol_i,
    output logic signed [VOL_W+12:0] prod_o
);

    logic [11:0]        tri_u;
    logic signed [11:0] wave;

    always_comb begin
        tri_u = phase_top_i[12] ? ~phase_top_i[11:0] : phase_top_i[11:0];
        wave  = '0;
        case (wave_sel_i)
            WAVE_SQUARE: wave = phase_top_i[12] ? WAVE_NEG_MAX : WAVE_POS_MAX;
            // x - 2048 on a 12-bit unsigned value is just an MSB flip read as signed
            WAVE_SAW:    wave = $signed({~phase_top_i[12], phase_top_i[11:1]});
            WAVE_TRI:    wave = $signed({~tri_u[11], tri_u[10:0]});
            default:     wave = '0;
        endcase
    end

    assign prod_o = $signed({{(VOL_W+1){wave[11]}}, wave}) * $signed({13'd0, vol_i});

endmodule

// File: rtl/voice_scheduler.sv
// Runs one shared phase/wave/volume datapath over all voices once per sample tick and emits the mixed sample.
// Valid 2*NUM_VOICES+1 cycles after an accepted tick; ticks arriving while busy are dropped and flagged.
module voice_scheduler
    import tone_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 16,
    parameter int FREQ_W     = 16,
    parameter int VOL_W      = 4,
    parameter int SAMPLE_W   = 16
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic                          sample_tick_in,
    output logic [$clog2(NUM_VOICES)-1:0] cfg_voice_idx_out,
    input  logic [FREQ_W-1:0]             cfg_freq_in,
    input  logic [VOL_W-1:0]              cfg_vol_in,
    input  logic [1:0]                    cfg_wave_in,
    output logic signed [SAMPLE_W-1:0]    sample_out,
    output logic                          sample_valid_out,
    output logic                          busy_out,
    output logic                          overrun_out
);

    localparam int IDX_W  = $clog2(NUM_VOICES);
    localparam int PROD_W = VOL_W + 13;
    localparam int ACC_W  = PROD_W + IDX_W;

    sched_state_e               state_q, state_d;
    logic [IDX_W-1:0]           vidx_q, vidx_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic [FREQ_W-1:0]          freq_q;
    logic [VOL_W-1:0]           vol_q;
    wave_sel_e                  wave_q;
    logic [PHASE_W-1:0]         phase_q [NUM_VOICES];
    logic signed [SAMPLE_W-1:0] sample_q;
    logic                       valid_q;

    logic [PHASE_W-1:0]         cur_phase;
    logic signed [PROD_W-1:0]   prod;
    logic                       last_voice;

    assign cur_phase  = phase_q[vidx_q];
    assign last_voice = (vidx_q == IDX_W'(NUM_VOICES - 1));

    voice_wave_gen #(
        .VOL_W (VOL_W)
    ) u_wave_gen (
        .phase_top_i (cur_phase[PHASE_W-1 -: 13]),
        .wave_sel_i  (wave_q),
        .vol_i       (vol_q),
        .prod_o      (prod)
    );

    always_comb begin
        state_d = state_q;
        vidx_d  = vidx_q;
        acc_d   = acc_q;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick_in) begin
                    state_d = ST_FETCH;
                    vidx_d  = '0;
                    acc_d   = '0;
                end
            end
            ST_FETCH: state_d = ST_ACC;
            ST_ACC: begin
                acc_d = acc_q + {{IDX_W{prod[PROD_W-1]}}, prod};
                if (last_voice) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FETCH;
                    vidx_d  = vidx_q + IDX_W'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state_q  <= ST_IDLE;
            vidx_q   <= '0;
            acc_q    <= '0;
            freq_q   <= '0;
            vol_q    <= '0;
            wave_q   <= WAVE_OFF;
            sample_q <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            vidx_q  <= vidx_d;
            acc_q   <= acc_d;
            valid_q <= 1'b0;
            if (state_q == ST_FETCH) begin
                freq_q <= cfg_freq_in;
                vol_q  <= cfg_vol_in;
                wave_q <= wave_sel_e'(cfg_wave_in);
            end
            if (state_q == ST_ACC) begin
                phase_q[vidx_q] <= cur_phase + PHASE_W'(freq_q);
                // Load the result on entry to DONE so data and valid line up in that cycle
                if (last_voice) begin
                    sample_q <= SAMPLE_W'(acc_d >>> IDX_W);
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign cfg_voice_idx_out = (state_q == ST_FETCH) ? vidx_q : '0;
    assign sample_out        = sample_q;
    assign sample_valid_out  = valid_q;
    assign busy_out          = (state_q != ST_IDLE);
    assign overrun_out       = sample_tick_in && (state_q != ST_IDLE);

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: register-file model, per-pass reference model and expected-sample queue.
module tb_voice_scheduler;

    logic              clk_in = 1'b0;
    logic              reset_in;
    logic              sample_tick_in;
    logic [1:0]        cfg_voice_idx_out;
    logic [15:0]       cfg_freq_in;
    logic [3:0]        cfg_vol_in;
    logic [1:0]        cfg_wave_in;
    logic signed [15:0] sample_out;
    logic              sample_valid_out;
    logic              busy_out;
    logic              overrun_out;

    logic [15:0] r_freq [4];
    logic [3:0]  r_vol  [4];
    logic [1:0]  r_wave [4];
    int          m_ph   [4];

    logic signed [31:0] exp_q [$];
    int tests = 0;
    int fails = 0;

    voice_scheduler dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .sample_tick_in    (sample_tick_in),
        .cfg_voice_idx_out (cfg_voice_idx_out),
        .cfg_freq_in       (cfg_freq_in),
        .cfg_vol_in        (cfg_vol_in),
        .cfg_wave_in       (cfg_wave_in),
        .sample_out        (sample_out),
        .sample_valid_out  (sample_valid_out),
        .busy_out          (busy_out),
        .overrun_out       (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    always_comb begin
        cfg_freq_in = r_freq[cfg_voice_idx_out];
        cfg_vol_in  = r_vol[cfg_voice_idx_out];
        cfg_wave_in = r_wave[cfg_voice_idx_out];
    end

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        tests++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_voice(input int v, input logic [15:0] f, input logic [3:0] vol, input logic [1:0] w);
        r_freq[v] = f;
        r_vol[v]  = vol;
        r_wave[v] = w;
    endtask

    // Reference: sum of wave*vol over voices from current model phases, then advance phases.
    task automatic model_pass(output logic signed [31:0] e);
        int sum;
        int p;
        int w;
        int b;
        int u;
        sum = 0;
        for (int v = 0; v < 4; v++) begin
            p = m_ph[v];
            b = (p >> 3) & 4095;
            case (r_wave[v])
                2'd0:    w = (p >= 32768) ? -2048 : 2047;
                2'd1:    w = (p >> 4) - 2048;
                2'd2: begin
                    u = (p >= 32768) ? (4095 - b) : b;
                    w = u - 2048;
                end
                default: w = 0;
            endcase
            sum = sum + w * int'(r_vol[v]);
            m_ph[v] = (p + int'(r_freq[v])) & 65535;
        end
        e = sum >>> 2;
    endtask

    task automatic do_reset();
        reset_in = 1'b1;
        @(posedge clk_in);
        #1;
        reset_in = 1'b0;
        for (int v = 0; v < 4; v++) m_ph[v] = 0;
    endtask

    task automatic pop_and_check(input string tag);
        logic signed [31:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_valid"}, 32'sd1, 32'sd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'($signed(sample_out)), e);
        end
    endtask

    // One full pass: tick in cycle 0, voice index checked each cycle, valid expected in cycle 9.
    task automatic run_pass(input string tag);
        logic signed [31:0] e;
        bit got;
        int exp_idx;
        model_pass(e);
        exp_q.push_back(e);
        got = 1'b0;
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            exp_idx = (k % 2 == 1 && k <= 7) ? (k - 1) / 2 : 0;
            check({tag, "_idx"}, {30'd0, cfg_voice_idx_out}, exp_idx);
            if (sample_valid_out) begin
                check({tag, "_latency"}, k, 9);
                pop_and_check(tag);
                got = 1'b1;
                break;
            end
            @(posedge clk_in);
            #1;
        end
        if (!got) check({tag, "_timeout"}, 32'sd0, 32'sd1);
        @(posedge clk_in);
        #1;
        check({tag, "_busy_after"}, {31'd0, busy_out}, 0);
    endtask

    initial begin
        int vcount;
        int vcycle;
        reset_in       = 1'b1;
        sample_tick_in = 1'b0;
        for (int v = 0; v < 4; v++) begin
            set_voice(v, 16'h0000, 4'd0, 2'd3);
            m_ph[v] = 0;
        end
        #1;
        check("rst_sample", 32'($signed(sample_out)), 0);
        check("rst_valid", {31'd0, sample_valid_out}, 0);
        check("rst_busy", {31'd0, busy_out}, 0);
        check("rst_overrun", {31'd0, overrun_out}, 0);
        check("rst_idx", {30'd0, cfg_voice_idx_out}, 0);
        repeat (2) @(posedge clk_in);
        #1;
        reset_in = 1'b0;

        // Saw on voice 0 only
        set_voice(0, 16'h1000, 4'd15, 2'd1);
        run_pass("saw1");
        run_pass("saw2");

        // Reset in the middle of a pass
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("mid_busy_pre", {31'd0, busy_out}, 1);
        reset_in       = 1'b1;
        sample_tick_in = 1'b1;
        #1;
        check("mid_sample", 32'($signed(sample_out)), 0);
        check("mid_valid", {31'd0, sample_valid_out}, 0);
        check("mid_busy", {31'd0, busy_out}, 0);
        check("mid_overrun", {31'd0, overrun_out}, 0);
        check("mid_idx", {30'd0, cfg_voice_idx_out}, 0);
        vcount = 0;
        repeat (3) begin
            @(posedge clk_in);
            #1;
            if (sample_valid_out) vcount++;
        end
        sample_tick_in = 1'b0;
        reset_in       = 1'b0;
        for (int v = 0; v < 4; v++) m_ph[v] = 0;
        repeat (12) begin
            @(posedge clk_in);
            #1;
            if (sample_valid_out) vcount++;
        end
        check("mid_no_valid", vcount, 0);

        // All voices square at full volume, half-cycle step
        for (int v = 0; v < 4; v++) set_voice(v, 16'h8000, 4'd15, 2'd0);
        run_pass("sq1");
        run_pass("sq2");

        // Overrun: second tick 3 cycles into a pass
        begin
            logic signed [31:0] e;
            model_pass(e);
            exp_q.push_back(e);
        end
        vcount = 0;
        vcycle = -1;
        @(posedge clk_in);
        #1;
        sample_tick_in = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk_in);
            #1;
            sample_tick_in = (k == 3);
            #1;
            if (k == 3) check("ovr_pulse", {31'd0, overrun_out}, 1);
            if (k == 4) check("ovr_clear", {31'd0, overrun_out}, 0);
            if (k == 10) check("ovr_busy10", {31'd0, busy_out}, 0);
            if (sample_valid_out) begin
                vcount++;
                vcycle = k;
                pop_and_check("ovr_sample");
            end
        end
        check("ovr_valid_count", vcount, 1);
        check("ovr_valid_cycle", vcycle, 9);

        // Phase wrap on voice 0; voice 1 off but still advancing
        do_reset();
        set_voice(0, 16'hFFFF, 4'd15, 2'd1);
        set_voice(1, 16'h2000, 4'd15, 2'd3);
        set_voice(2, 16'h0000, 4'd0, 2'd3);
        set_voice(3, 16'h0000, 4'd0, 2'd3);
        run_pass("wrap1");
        run_pass("wrap2");
        run_pass("wrap3");
        set_voice(0, 16'hFFFF, 4'd15, 2'd3);
        set_voice(1, 16'h0000, 4'd15, 2'd1);
        run_pass("off_adv");

        // Triangle, unit volume, quarter-cycle step
        do_reset();
        set_voice(0, 16'h4000, 4'd1, 2'd2);
        set_voice(1, 16'h0000, 4'd0, 2'd3);
        for (int i = 0; i < 4; i++) run_pass($sformatf("tri%0d", i));

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
